// File: rtl/fpu_test_pkg.sv
// Shared definitions for the FPU test-vector sequencer.
// Holds the sequencer state encoding, the ROM geometry and the
// operand-width legality check used by the elaboration guard.
package fpu_test_pkg;

    // Depth of each operand ROM; the address bus spans it exactly.
    localparam int unsigned ROM_DEPTH = 1024;
    localparam int unsigned ADDR_W    = $clog2(ROM_DEPTH);
    // One extra bit so the count can hold ROM_DEPTH itself.
    localparam int unsigned CNT_W     = ADDR_W + 1;
    localparam int unsigned STATE_W   = 3;

    // Sequencer state encoding.
    localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ST_FETCH    = 3'd1;
    localparam logic [STATE_W-1:0] ST_ISSUE    = 3'd2;
    localparam logic [STATE_W-1:0] ST_WAIT_RES = 3'd3;
    localparam logic [STATE_W-1:0] ST_SEND     = 3'd4;
    localparam logic [STATE_W-1:0] ST_DONE     = 3'd5;

    // Operand width must match a supported FPU format.
    function automatic bit w_is_legal(input int unsigned w);
        return (w == 32) || (w == 64);
    endfunction

endpackage

// File: rtl/timeout_counter.sv
// Result-wait watchdog for the vector sequencer.
// Ports: clk, rst (sync, active-high); clear restarts the count;
// enable counts one waiting cycle; expired is high in the TIMEOUT-th
// enabled cycle after a clear and stays high until the next clear.
module timeout_counter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = 17;

    logic [CNT_W-1:0] count;

    // expired is computed one cycle ahead so it can be a plain register:
    // in enabled cycle k (counting from 1) it reads (k >= TIMEOUT).
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (clear) begin
            count   <= '0;
            expired <= (TIMEOUT <= 32'd1);
        end else if (enable && !expired) begin
            count   <= count + CNT_W'(1);
            expired <= ((32'(count) + 32'd2) >= TIMEOUT);
        end
    end

endmodule

// File: rtl/rom_vector_sequencer.sv
// Walks ROM addresses 0..LAST_ADDR, hands each operand pair to an FPU,
// waits (bounded) for the result and forwards it to a UART framer.
// Ports: clk, rst (sync, active-high); start pulse; addr to both ROMs and
// rom_a_data/rom_b_data back; op_valid/op_ready/op_a/op_b to the FPU;
// res_valid/res_data from the FPU; tx_valid/tx_ready/tx_data to the
// framer; busy/done/timeout_err status and vec_count of vectors sent.
module rom_vector_sequencer
    import fpu_test_pkg::*;
#(
    parameter int unsigned W         = 32,
    parameter int unsigned LAST_ADDR = 1023,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] addr,
    input  logic [W-1:0]      rom_a_data,
    input  logic [W-1:0]      rom_b_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [W-1:0]      op_a,
    output logic [W-1:0]      op_b,
    input  logic              res_valid,
    input  logic [W-1:0]      res_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [W-1:0]      tx_data,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  vec_count
);

    // Elaboration guards on parameter ranges.
    if (!w_is_legal(W)) begin : g_bad_w
        $error("rom_vector_sequencer: W must be 32 or 64");
    end
    if (LAST_ADDR >= ROM_DEPTH) begin : g_bad_last
        $error("rom_vector_sequencer: LAST_ADDR out of range");
    end

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    logic [STATE_W-1:0] state, state_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [W-1:0]       op_a_nxt, op_b_nxt, tx_data_nxt;
    logic [CNT_W-1:0]   vec_count_nxt;
    logic               timeout_err_nxt;
    logic               op_valid_nxt, tx_valid_nxt, busy_nxt, done_nxt;
    logic               tmr_clear, tmr_enable, tmr_expired;

    timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    // Next-state and next-output logic; strobes are derived from the
    // next state so every output leaves a register.
    always_comb begin
        state_nxt       = state;
        addr_nxt        = addr;
        op_a_nxt        = op_a;
        op_b_nxt        = op_b;
        tx_data_nxt     = tx_data;
        vec_count_nxt   = vec_count;
        timeout_err_nxt = timeout_err;
        tmr_clear       = 1'b0;
        tmr_enable      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt       = ST_FETCH;
                    addr_nxt        = '0;
                    vec_count_nxt   = '0;
                    timeout_err_nxt = 1'b0;
                end
            end
            ST_FETCH: begin
                op_a_nxt  = rom_a_data;
                op_b_nxt  = rom_b_data;
                state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (op_valid && op_ready) begin
                    tmr_clear = 1'b1;
                    state_nxt = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                tmr_enable = 1'b1;
                if (res_valid) begin
                    tx_data_nxt = res_data;
                    state_nxt   = ST_SEND;
                end else if (tmr_expired) begin
                    timeout_err_nxt = 1'b1;
                    tx_data_nxt     = '0;
                    state_nxt       = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_valid && tx_ready) begin
                    vec_count_nxt = vec_count + CNT_W'(1);
                    if (addr == LAST) begin
                        state_nxt = ST_DONE;
                    end else begin
                        addr_nxt  = addr + ADDR_W'(1);
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        op_valid_nxt = (state_nxt == ST_ISSUE);
        tx_valid_nxt = (state_nxt == ST_SEND);
        done_nxt     = (state_nxt == ST_DONE);
        busy_nxt     = (state_nxt == ST_FETCH) || (state_nxt == ST_ISSUE) ||
                       (state_nxt == ST_WAIT_RES) || (state_nxt == ST_SEND);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            addr        <= '0;
            op_a        <= '0;
            op_b        <= '0;
            tx_data     <= '0;
            vec_count   <= '0;
            timeout_err <= 1'b0;
            op_valid    <= 1'b0;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            addr        <= addr_nxt;
            op_a        <= op_a_nxt;
            op_b        <= op_b_nxt;
            tx_data     <= tx_data_nxt;
            vec_count   <= vec_count_nxt;
            timeout_err <= timeout_err_nxt;
            op_valid    <= op_valid_nxt;
            tx_valid    <= tx_valid_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

endmodule
